// File: rtl/row_bias.sv
// -----------------------------------------------------------------------------
// row_bias
//
// Responder side of the tile rowbias request interface. One instance serves
// one grid row. It holds that row's bias table, which is always a permutation
// of the GRID_LEN one-hot values. It answers an indexed request with a
// registered one-hot reply. On command it reshuffles the table in place using
// an LFSR-driven Fisher-Yates pass.
//
// Handshake semantics (the only handshake in this block):
//   - A request is accepted at a rising edge of clock when updaterowbias is
//     high and the block is in IDLE (ready high). rqindex is sampled at that
//     same edge.
//   - The reply appears on rowbias after that edge. It holds until the next
//     accepted request, or until a request arrives during a shuffle, which
//     forces rowbias to zero.
//   - A reseed is accepted at a rising edge only when ready is high. ready
//     stays low for exactly GRID_LEN-1 cycles while the shuffle runs.
//
// Parameters:
//   GRID_LEN      number of values per row (2..64)
//
// Ports:
//   clock          clock
//   reset          synchronous, active-high reset
//   rqindex        [GRID_LEN:0] one-hot request index; bit GRID_LEN = sentinel
//   updaterowbias  request strobe
//   rowbias        [GRID_LEN-1:0] registered one-hot reply (zero for sentinel
//                  or invalid request)
//   reseed         start a reshuffle
//   seed           [15:0] LFSR seed, sampled with reseed (0 maps to 16'hACE1)
//   ready          high in IDLE, low while shuffling
//   badreq         sticky flag: accepted request with non-one-hot rqindex
//   dbg_state      current FSM state (0 = IDLE, 1 = SHUFFLE)
// -----------------------------------------------------------------------------
module row_bias #(
   parameter int GRID_LEN = 9
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [GRID_LEN:0]   rqindex,
   input  logic                updaterowbias,
   output logic [GRID_LEN-1:0] rowbias,
   input  logic                reseed,
   input  logic [15:0]         seed,
   output logic                ready,
   output logic                badreq,
   output logic                dbg_state
);

   // Width of the shuffle index i (counts GRID_LEN-1 down to 1).
   localparam int IW = $clog2(GRID_LEN);
   // Width needed to hold i+1, which can reach GRID_LEN.
   localparam int CW = $clog2(GRID_LEN + 1);
   // Full width of lfsr[7:0] * (i+1), kept untruncated before the shift.
   localparam int PW = 8 + CW;
   // Width of the request index, including the sentinel bit.
   localparam int RW = GRID_LEN + 1;

   localparam logic [15:0] LFSR_INIT = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_SHUFFLE = 1'b1;

   logic [0:0]          state_q;
   logic [15:0]         lfsr_q;
   logic [IW-1:0]       i_q;
   logic [GRID_LEN-1:0] tbl [GRID_LEN];

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic                req_onehot;
   logic [GRID_LEN-1:0] reply_sel;

   // A value is one-hot when it is nonzero and clearing its lowest set bit
   // leaves nothing. This treats the sentinel bit like any other bit. The
   // sentinel then simply selects no table entry.
   always_comb begin
      req_onehot = (rqindex != '0) && ((rqindex & (rqindex - RW'(1))) == '0);
      reply_sel  = '0;
      for (int k = 0; k < GRID_LEN; k++) begin
         if (rqindex[k]) begin
            reply_sel = reply_sel | tbl[k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Shuffle datapath
   // ---------------------------------------------------------------------------
   logic [CW-1:0]       i_plus;
   logic [PW-1:0]       prod;
   logic [CW-1:0]       j_wide;
   logic [IW-1:0]       j;
   logic [GRID_LEN-1:0] tbl_i;
   logic [GRID_LEN-1:0] tbl_j;
   logic [15:0]         lfsr_next;
   logic [15:0]         seed_eff;

   // j = (lfsr[7:0] * (i+1)) >> 8 always lands in 0..i. The truncation to
   // IW bits therefore never loses information.
   always_comb begin
      i_plus    = CW'(i_q) + CW'(1);
      prod      = PW'(lfsr_q[7:0]) * PW'(i_plus);
      j_wide    = prod[PW-1:8];
      j         = IW'(j_wide);
      tbl_i     = tbl[i_q];
      tbl_j     = tbl[j];
      lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      seed_eff  = (seed == 16'h0000) ? LFSR_INIT : seed;
   end

   // ---------------------------------------------------------------------------
   // State, table and outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lfsr_q  <= LFSR_INIT;
         i_q     <= '0;
         rowbias <= '0;
         badreq  <= 1'b0;
         for (int k = 0; k < GRID_LEN; k++) begin
            tbl[k] <= GRID_LEN'(1) << k;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               // The request reads the current table. A reseed in the same
               // cycle therefore serves it from the pre-shuffle contents.
               if (updaterowbias) begin
                  if (req_onehot) begin
                     rowbias <= reply_sel;
                  end else begin
                     rowbias <= '0;
                     badreq  <= 1'b1;
                  end
               end
               if (reseed) begin
                  lfsr_q  <= seed_eff;
                  i_q     <= IW'(GRID_LEN - 1);
                  state_q <= ST_SHUFFLE;
               end
            end

            ST_SHUFFLE: begin
               // Requests are not served mid-shuffle. They read as zero and
               // are not counted as bad requests. reseed is ignored.
               if (updaterowbias) begin
                  rowbias <= '0;
               end
               // Swap entries i and j. When j == i, both branches pick the
               // same slot and write back its own value.
               for (int k = 0; k < GRID_LEN; k++) begin
                  if (IW'(k) == i_q) begin
                     tbl[k] <= tbl_j;
                  end else if (IW'(k) == j) begin
                     tbl[k] <= tbl_i;
                  end
               end
               lfsr_q <= lfsr_next;
               i_q    <= i_q - IW'(1);
               if (i_q == IW'(1)) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign dbg_state = state_q[0];

   // ---------------------------------------------------------------------------
   // Table invariant: every entry is one-hot and together they cover every bit
   // ---------------------------------------------------------------------------
   logic [GRID_LEN-1:0] tbl_union;
   logic                tbl_all_onehot;

   always_comb begin
      tbl_union      = '0;
      tbl_all_onehot = 1'b1;
      for (int k = 0; k < GRID_LEN; k++) begin
         tbl_union = tbl_union | tbl[k];
         if ((tbl[k] == '0) || ((tbl[k] & (tbl[k] - GRID_LEN'(1))) != '0)) begin
            tbl_all_onehot = 1'b0;
         end
      end
   end

   table_is_permutation: assert property (
      @(posedge clock) disable iff (reset)
      tbl_all_onehot && (tbl_union == {GRID_LEN{1'b1}})
   );

endmodule

// File: tb/tb_row_bias.sv
// -----------------------------------------------------------------------------
// tb_row_bias
//
// Directed bench for row_bias with GRID_LEN = 9. Each scenario task drives its
// own stimulus and compares outputs inline. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_row_bias;

   localparam int GL = 9;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [GL:0]   rqindex = '0;
   logic          updaterowbias = 1'b0;
   logic [GL-1:0] rowbias;
   logic          reseed = 1'b0;
   logic [15:0]   seed = '0;
   logic          ready;
   logic          badreq;
   logic          dbg_state;

   int checks = 0;
   int errors = 0;

   logic [GL-1:0] exp_tbl [GL];

   row_bias #(.GRID_LEN(GL)) dut (
      .clock         (clock),
      .reset         (reset),
      .rqindex       (rqindex),
      .updaterowbias (updaterowbias),
      .rowbias       (rowbias),
      .reseed        (reseed),
      .seed          (seed),
      .ready         (ready),
      .badreq        (badreq),
      .dbg_state     (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      updaterowbias = 1'b0;
      reseed = 1'b0;
      rqindex = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic read_index(input int b, output logic [GL-1:0] v);
      logic [GL:0] one;
      one = 1;
      rqindex = one << b;
      updaterowbias = 1'b1;
      step();
      v = rowbias;
      updaterowbias = 1'b0;
      rqindex = '0;
   endtask

   // Counts cycles with ready low, starting from the current observation.
   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 50) begin
         cnt++;
         step();
      end
   endtask

   // Reference Fisher-Yates on an identity table, straight from the formula.
   task automatic model_shuffle(input logic [15:0] s);
      logic [15:0]   l;
      logic [GL-1:0] tmp;
      int            prod;
      int            j;
      for (int k = 0; k < GL; k++) exp_tbl[k] = GL'(1) << k;
      l = s;
      for (int i = GL - 1; i >= 1; i--) begin
         prod = int'(l[7:0]) * (i + 1);
         j = prod / 256;
         tmp = exp_tbl[i];
         exp_tbl[i] = exp_tbl[j];
         exp_tbl[j] = tmp;
         l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset;
      do_reset();
      checks++; if (rowbias !== 9'b0) begin errors++; $display("FAIL reset_rowbias: got %b expected %b", rowbias, 9'b0); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (badreq !== 1'b0) begin errors++; $display("FAIL reset_badreq: got %b expected 0", badreq); end
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
   endtask

   task automatic test_single;
      logic [GL-1:0] v;
      do_reset();
      read_index(2, v);
      checks++; if (v !== 9'b000000100) begin errors++; $display("FAIL single_reply: got %b expected %b", v, 9'b000000100); end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (rowbias !== 9'b000000100) begin errors++; $display("FAIL single_hold%0d: got %b expected %b", c, rowbias, 9'b000000100); end
      end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", ready); end
      checks++; if (badreq !== 1'b0) begin errors++; $display("FAIL single_badreq: got %b expected 0", badreq); end
   endtask

   task automatic test_sweep;
      logic [GL-1:0] v;
      logic [GL-1:0] e;
      logic [GL:0]   one;
      one = 1;
      // back-to-back: strobe held high, one request per cycle
      updaterowbias = 1'b1;
      for (int b = 0; b <= GL; b++) begin
         rqindex = one << b;
         step();
         v = rowbias;
         e = (b < GL) ? (GL'(1) << b) : '0;
         checks++; if (v !== e) begin errors++; $display("FAIL sweep_bit%0d: got %b expected %b", b, v, e); end
      end
      updaterowbias = 1'b0;
      rqindex = '0;
      checks++; if (badreq !== 1'b0) begin errors++; $display("FAIL sweep_badreq: got %b expected 0", badreq); end
   endtask

   task automatic test_badreq;
      logic [GL-1:0] v;
      do_reset();
      read_index(4, v);   // make rowbias nonzero first
      rqindex = '0;
      updaterowbias = 1'b1;
      step();
      checks++; if (rowbias !== 9'b0) begin errors++; $display("FAIL bad_zero_reply: got %b expected 0", rowbias); end
      checks++; if (badreq !== 1'b1) begin errors++; $display("FAIL bad_zero_flag: got %b expected 1", badreq); end
      rqindex = 10'b0000000011;
      step();
      checks++; if (rowbias !== 9'b0) begin errors++; $display("FAIL bad_multi_reply: got %b expected 0", rowbias); end
      updaterowbias = 1'b0;
      rqindex = '0;
      read_index(1, v);   // a good request does not clear the flag
      checks++; if (v !== 9'b000000010) begin errors++; $display("FAIL bad_good_after: got %b expected %b", v, 9'b000000010); end
      for (int c = 0; c < 3; c++) step();
      checks++; if (badreq !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", badreq); end
      do_reset();
      checks++; if (badreq !== 1'b0) begin errors++; $display("FAIL bad_cleared: got %b expected 0", badreq); end
   endtask

   task automatic test_reseed(input string name, input logic [15:0] s, input logic [15:0] model_seed);
      logic [GL-1:0] v;
      logic [GL-1:0] uni;
      int            n;
      do_reset();
      model_shuffle(model_seed);
      seed = s;
      reseed = 1'b1;
      step();
      reseed = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL %s_ready_low: got %b expected 0", name, ready); end
      checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL %s_state: got %b expected 1", name, dbg_state); end
      wait_ready(n);
      checks++; if (n != GL - 1) begin errors++; $display("FAIL %s_length: got %0d expected %0d", name, n, GL - 1); end
      uni = '0;
      for (int b = 0; b < GL; b++) begin
         read_index(b, v);
         uni = uni | v;
         checks++; if (v !== exp_tbl[b]) begin errors++; $display("FAIL %s_read%0d: got %b expected %b", name, b, v, exp_tbl[b]); end
      end
      checks++; if (uni !== 9'h1FF) begin errors++; $display("FAIL %s_perm: got %b expected %b", name, uni, 9'h1FF); end
   endtask

   task automatic test_shuffle_ignored;
      logic [GL-1:0] v;
      int            n;
      do_reset();
      model_shuffle(16'h0001);
      read_index(0, v);   // rowbias = 1 going in
      seed = 16'h0001;
      reseed = 1'b1;
      step();             // edge T
      reseed = 1'b0;
      step();             // edge T+1
      rqindex = 10'b0000000001;
      updaterowbias = 1'b1;
      seed = 16'h1234;
      reseed = 1'b1;
      step();             // edge T+2
      updaterowbias = 1'b0;
      reseed = 1'b0;
      rqindex = '0;
      checks++; if (rowbias !== 9'b0) begin errors++; $display("FAIL ign_rowbias: got %b expected 0", rowbias); end
      checks++; if (badreq !== 1'b0) begin errors++; $display("FAIL ign_badreq: got %b expected 0", badreq); end
      wait_ready(n);
      checks++; if (n + 2 != GL - 1) begin errors++; $display("FAIL ign_length: got %0d expected %0d", n + 2, GL - 1); end
      for (int b = 0; b < GL; b++) begin
         read_index(b, v);
         checks++; if (v !== exp_tbl[b]) begin errors++; $display("FAIL ign_read%0d: got %b expected %b", b, v, exp_tbl[b]); end
      end
   endtask

   task automatic test_reset_mid;
      logic [GL-1:0] v;
      logic [GL-1:0] e;
      do_reset();
      seed = 16'h0001;
      reseed = 1'b1;
      step();
      reseed = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready); end
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL mid_state: got %b expected 0", dbg_state); end
      for (int b = 0; b < GL; b++) begin
         read_index(b, v);
         e = GL'(1) << b;
         checks++; if (v !== e) begin errors++; $display("FAIL mid_read%0d: got %b expected %b", b, v, e); end
      end
   endtask

   task automatic test_request_with_reseed;
      logic [GL-1:0] v;
      int            n;
      do_reset();
      model_shuffle(16'h0001);
      rqindex = 10'b0000001000;
      updaterowbias = 1'b1;
      seed = 16'h0001;
      reseed = 1'b1;
      step();
      updaterowbias = 1'b0;
      reseed = 1'b0;
      rqindex = '0;
      checks++; if (rowbias !== 9'b000001000) begin errors++; $display("FAIL both_reply: got %b expected %b", rowbias, 9'b000001000); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL both_ready: got %b expected 0", ready); end
      wait_ready(n);
      checks++; if (n != GL - 1) begin errors++; $display("FAIL both_length: got %0d expected %0d", n, GL - 1); end
      for (int b = 0; b < GL; b++) begin
         read_index(b, v);
         checks++; if (v !== exp_tbl[b]) begin errors++; $display("FAIL both_read%0d: got %b expected %b", b, v, exp_tbl[b]); end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single();
      test_sweep();
      test_badreq();
      test_reseed("seed1", 16'h0001, 16'h0001);
      test_reseed("seed0", 16'h0000, 16'hACE1);
      test_reseed("seedace1", 16'hACE1, 16'hACE1);
      test_shuffle_ignored();
      test_reset_mid();
      test_request_with_reseed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
